stress_meter: RTL and testbench
===============================

STRESS_METER -- requirements
Module: stress_meter

Interface
REQ-001 Parameter SAMPLE_W, 8, DSP sample width.
REQ-002 Parameter WIN_LOG2, 4, log2 of samples per averaging window (2^WIN_LOG2 samples).
REQ-003 Parameter TH_LOW, 8'd64, average threshold for medium stress.
REQ-004 Parameter TH_HIGH, 8'd160, average threshold for high stress; TH_LOW < TH_HIGH.
REQ-005 Parameter HYST, 8'd8, hysteresis on falling thresholds; HYST <= TH_LOW.
REQ-006 Parameter CONT_WIN, 4, consecutive high windows before stress_continu asserts.
REQ-007 Parameter MEAS_TICKS, 60, tick strobes per heartbeat measurement period.
REQ-008 Parameter HART_TH, 8'd140, heartbeat count above which stress is raised.
REQ-009 clk  in  1  single system clock, rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 tick  in  1  one-cycle slow-time strobe (slow4 domain rate).
REQ-012 dsp_data  in  SAMPLE_W  cry-volume sample from DSP.
REQ-013 dsp_ready  in  1  DSP sample-valid level; may stay high for several cycles.
REQ-014 hart_in  in  1  synchronous heartbeat pulse level.
REQ-015 huil_vol  out  SAMPLE_W  last completed window average.
REQ-016 stress_level  out  2  0 calm, 1 medium, 2 high; 3 never driven.
REQ-017 stress_laag  out  1  high when stress_level == 0.
REQ-018 stress_continu  out  1  sustained high stress.
REQ-019 hart_rate  out  8  heartbeats in last completed measurement period.

Function
REQ-020 Sample SHALL be captured only on the cycle dsp_ready rises (0->1); held-high ready SHALL capture once.
REQ-021 FSM states IDLE (no sample since reset), ACCUM (summing), EVAL (one cycle, update outputs); IDLE->ACCUM on first capture, ACCUM->EVAL on capture of the 2^WIN_LOG2-th sample, EVAL->ACCUM always.
REQ-022 Accumulator SHALL be SAMPLE_W+WIN_LOG2 bits, never overflow; average = accumulator >> WIN_LOG2 (truncating).
REQ-023 huil_vol and stress_level SHALL update at end of EVAL: one cycle after the window's last capture.
REQ-024 A capture during EVAL SHALL be sample 1 of the next window (accumulator loaded, count = 1); no sample lost.
REQ-025 Level rises: avg >= TH_HIGH -> 2; else avg >= TH_LOW -> max(current,1).
REQ-026 Level falls: from 2, avg < TH_HIGH-HYST -> 1, and avg < TH_LOW-HYST -> 0; from 1, avg < TH_LOW-HYST -> 0; otherwise hold.
REQ-027 stress_continu SHALL assert at the EVAL where high-window count reaches CONT_WIN, and clear at the first EVAL with final level < 2; counter saturates at CONT_WIN.
REQ-028 Heartbeat path SHALL count hart_in rising edges, saturating at 255, and latch count into hart_rate every MEAS_TICKS tick strobes, then restart; an edge coinciding with the period boundary counts in the new period.
REQ-029 Level computed in REQ-025/026 SHALL be raised by one (saturating at 2) when hart_rate > HART_TH, applied at EVAL.

Reset
REQ-030 Reset SHALL force state IDLE, accumulator, counts, edge registers to 0, huil_vol 0, stress_level 0, stress_laag 1, stress_continu 0, hart_rate 0, immediately and asynchronously, including mid-window (partial window discarded).

Configuration
REQ-031 Macro STRESS_HEART_EN defined: REQ-028/029 compiled in.
REQ-032 Macro absent: no heartbeat logic, hart_rate tied 0, hart_in and tick unused, level from volume only.

Structure
REQ-033 Package stress_pkg SHALL hold the level typedef (CALM/MEDIUM/HIGH) and FSM state typedef.
REQ-034 Heartbeat counter SHALL be sub-module pulse_rate_counter, instantiated under STRESS_HEART_EN.

Verification (SAMPLE_W=8, WIN_LOG2=2, CONT_WIN=2, MEAS_TICKS=4, HART_TH=3)
REQ-035 Samples 100,100,100,104 -> huil_vol=101, stress_level=1, stress_laag=0 one cycle after 4th capture.
REQ-036 dsp_ready held high 10 cycles with data 200 -> exactly one capture; window not complete.
REQ-037 Windows avg 200,200 -> stress_continu=1 at second EVAL; next window avg 155 -> level stays 2, continu stays 1 (hysteresis); avg 150 -> level 1, continu 0.
REQ-038 Capture on EVAL cycle, then 3 more of 0 after window avg 64 -> next huil_vol = first sample/4, no sample dropped.
REQ-039 Reset asserted after 2 of 4 captures -> all outputs at reset values same cycle; new window starts fresh after release.
REQ-040 STRESS_HEART_EN: 5 hart_in pulses within 4 ticks, volume avg 70 -> hart_rate=5, stress_level=2; without macro -> hart_rate=0, level=1.

Source files
------------

// File: rtl/stress_pkg.sv
// Shared types for the stress meter: level encoding, window FSM states and the
// heart-rate level bump helper.
package stress_pkg;

  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned RATE_W  = 8;

  typedef enum logic [LEVEL_W-1:0] {
    CALM   = 2'd0,
    MEDIUM = 2'd1,
    HIGH   = 2'd2
  } level_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  // Raise a level by one step, saturating at HIGH.
  function automatic level_t bump_level(input level_t lvl);
    return (lvl == CALM) ? MEDIUM : HIGH;
  endfunction

endpackage

// File: rtl/stress_meter_if.sv
// DSP sample bus: a data word qualified by a ready level.
interface stress_meter_if #(
  parameter int unsigned SAMPLE_W = 8
);
  logic [SAMPLE_W-1:0] dsp_data;
  logic                dsp_ready;

  modport master (output dsp_data, output dsp_ready);
  modport slave  (input  dsp_data, input  dsp_ready);
endinterface

// File: rtl/pulse_rate_counter.sv
// Counts rising edges of a pulse level over MEAS_TICKS tick strobes and latches
// the total at each period boundary.
module pulse_rate_counter
  import stress_pkg::*;
#(
  parameter int unsigned MEAS_TICKS = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              pulse,
  output logic [RATE_W-1:0] rate
);

  localparam int unsigned TICK_W = (MEAS_TICKS > 1) ? $clog2(MEAS_TICKS) : 1;

  logic              pulse_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [RATE_W-1:0] cnt;
  logic              pulse_rise_c;
  logic              period_end_c;

  assign pulse_rise_c = pulse & ~pulse_q;
  assign period_end_c = tick && (tick_cnt == TICK_W'(MEAS_TICKS - 1));

  // An edge landing on the boundary cycle seeds the new period's count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q  <= 1'b0;
      tick_cnt <= '0;
      cnt      <= '0;
      rate     <= '0;
    end else begin
      pulse_q <= pulse;
      if (period_end_c) begin
        rate     <= cnt;
        cnt      <= RATE_W'(pulse_rise_c);
        tick_cnt <= '0;
      end else begin
        if (tick) tick_cnt <= tick_cnt + TICK_W'(1);
        if (pulse_rise_c && (cnt != '1)) cnt <= cnt + RATE_W'(1);
      end
    end
  end

endmodule

// File: rtl/stress_meter.sv
// Windowed cry-volume averager with hysteretic stress level; optional
// heart-rate boost compiled in with STRESS_HEART_EN.
module stress_meter
  import stress_pkg::*;
#(
  parameter int unsigned         SAMPLE_W   = 8,
  parameter int unsigned         WIN_LOG2   = 4,
  parameter logic [SAMPLE_W-1:0] TH_LOW     = SAMPLE_W'(64),
  parameter logic [SAMPLE_W-1:0] TH_HIGH    = SAMPLE_W'(160),
  parameter logic [SAMPLE_W-1:0] HYST       = SAMPLE_W'(8),
  parameter int unsigned         CONT_WIN   = 4,
  parameter int unsigned         MEAS_TICKS = 60,
  parameter logic [RATE_W-1:0]   HART_TH    = RATE_W'(140)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                hart_in,
  stress_meter_if.slave       dsp,
  output logic [SAMPLE_W-1:0] huil_vol,
  output logic [LEVEL_W-1:0]  stress_level,
  output logic                stress_laag,
  output logic                stress_continu,
  output logic [RATE_W-1:0]   hart_rate
);

  localparam int unsigned         ACC_W     = SAMPLE_W + WIN_LOG2;
  localparam int unsigned         CNT_W     = WIN_LOG2 + 1;
  localparam int unsigned         CONT_W    = $clog2(CONT_WIN + 1);
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [SAMPLE_W-1:0] FALL_HIGH = TH_HIGH - HYST;
  localparam logic [SAMPLE_W-1:0] FALL_LOW  = TH_LOW - HYST;

  state_t            state;
  logic              ready_q;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [CONT_W-1:0] high_cnt;
  level_t            vol_lvl;

  logic                cap_c;
  logic [SAMPLE_W-1:0] avg_c;
  level_t              vol_next_c;
  level_t              lvl_next_c;
  logic [CONT_W-1:0]   high_next_c;

  assign cap_c = dsp.dsp_ready & ~ready_q;
  assign avg_c = SAMPLE_W'(acc >> WIN_LOG2);

  // Hysteresis runs on the volume-only level; the heart boost sits on top.
  always_comb begin
    vol_next_c = vol_lvl;
    if (avg_c >= TH_HIGH) begin
      vol_next_c = HIGH;
    end else begin
      if ((vol_lvl == HIGH) && (avg_c < FALL_HIGH)) vol_next_c = MEDIUM;
      if ((vol_lvl != CALM) && (avg_c < FALL_LOW))  vol_next_c = CALM;
      if ((avg_c >= TH_LOW) && (vol_next_c == CALM)) vol_next_c = MEDIUM;
    end
    lvl_next_c = vol_next_c;
`ifdef STRESS_HEART_EN
    if (hart_rate > HART_TH) lvl_next_c = bump_level(vol_next_c);
`endif
    high_next_c = '0;
    if (lvl_next_c == HIGH)
      high_next_c = (high_cnt == CONT_W'(CONT_WIN)) ? high_cnt : high_cnt + CONT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      ready_q        <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      high_cnt       <= '0;
      vol_lvl        <= CALM;
      huil_vol       <= '0;
      stress_level   <= CALM;
      stress_laag    <= 1'b1;
      stress_continu <= 1'b0;
    end else begin
      ready_q <= dsp.dsp_ready;
      case (state)
        S_IDLE: begin
          if (cap_c) begin
            acc   <= ACC_W'(dsp.dsp_data);
            cnt   <= CNT_W'(1);
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (cap_c) begin
            acc <= acc + ACC_W'(dsp.dsp_data);
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state <= S_EVAL;
          end
        end
        S_EVAL: begin
          huil_vol       <= avg_c;
          vol_lvl        <= vol_next_c;
          stress_level   <= lvl_next_c;
          stress_laag    <= (lvl_next_c == CALM);
          high_cnt       <= high_next_c;
          stress_continu <= (high_next_c == CONT_W'(CONT_WIN));
          // A capture here opens the next window rather than being dropped.
          acc   <= cap_c ? ACC_W'(dsp.dsp_data) : '0;
          cnt   <= cap_c ? CNT_W'(1) : '0;
          state <= S_ACCUM;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STRESS_HEART_EN
  pulse_rate_counter #(
    .MEAS_TICKS (MEAS_TICKS)
  ) u_rate (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .pulse (hart_in),
    .rate  (hart_rate)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{tick, hart_in, HART_TH, MEAS_TICKS};
  assign hart_rate = '0;
`endif

endmodule

// File: tb/tb_stress_meter.sv
// Directed bench for stress_meter: window table plus corner sequences.
module tb_stress_meter;

  localparam int unsigned SW = 8;
`ifdef STRESS_HEART_EN
  localparam bit HEART = 1'b1;
`else
  localparam bit HEART = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          hart_in = 1'b0;
  logic [SW-1:0] huil_vol;
  logic [1:0]    stress_level;
  logic          stress_laag;
  logic          stress_continu;
  logic [7:0]    hart_rate;

  int n_run  = 0;
  int n_fail = 0;

  stress_meter_if #(.SAMPLE_W(SW)) dsp ();

  stress_meter #(
    .SAMPLE_W   (SW),
    .WIN_LOG2   (2),
    .TH_LOW     (8'd64),
    .TH_HIGH    (8'd160),
    .HYST       (8'd8),
    .CONT_WIN   (2),
    .MEAS_TICKS (4),
    .HART_TH    (8'd3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .hart_in        (hart_in),
    .dsp            (dsp),
    .huil_vol       (huil_vol),
    .stress_level   (stress_level),
    .stress_laag    (stress_laag),
    .stress_continu (stress_continu),
    .hart_rate      (hart_rate)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [7:0]      vol;
    logic [1:0]      lvl;
    logic            cont;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] vol, input logic [1:0] lvl,
                              input logic cont);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.vol = vol; v.lvl = lvl; v.cont = cont;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] vol, input logic [1:0] lvl,
                         input logic cont);
    chk({name, ".huil_vol"}, 32'(huil_vol), 32'(vol));
    chk({name, ".level"}, 32'(stress_level), 32'(lvl));
    chk({name, ".laag"}, 32'(stress_laag), 32'(lvl == 2'd0));
    chk({name, ".continu"}, 32'(stress_continu), 32'(cont));
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    dsp.dsp_data  = d;
    dsp.dsp_ready = 1'b1;
    @(negedge clk);
    dsp.dsp_ready = 1'b0;
  endtask

  task automatic send4(input logic [7:0] d);
    for (int k = 0; k < 4; k++) send(d);
  endtask

  task automatic after_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_hart();
    @(negedge clk); hart_in = 1'b1;
    @(negedge clk); hart_in = 1'b0;
  endtask

  task automatic strobe(input logic with_hart);
    @(negedge clk); tick = 1'b1; hart_in = with_hart;
    @(negedge clk); tick = 1'b0; hart_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dsp.dsp_data  = '0;
    dsp.dsp_ready = 1'b0;

    tbl[0]  = mk(100, 100, 100, 104, 101, 1, 0);
    tbl[1]  = mk(200, 200, 200, 200, 200, 2, 0);
    tbl[2]  = mk(200, 200, 200, 200, 200, 2, 1);
    tbl[3]  = mk(155, 155, 155, 155, 155, 2, 1);
    tbl[4]  = mk(150, 150, 150, 150, 150, 1, 0);
    tbl[5]  = mk(60, 60, 60, 60, 60, 1, 0);
    tbl[6]  = mk(50, 50, 50, 50, 50, 0, 0);
    tbl[7]  = mk(60, 60, 60, 60, 60, 0, 0);
    tbl[8]  = mk(64, 64, 64, 64, 64, 1, 0);
    tbl[9]  = mk(160, 160, 160, 160, 160, 2, 0);
    tbl[10] = mk(152, 152, 152, 152, 152, 2, 1);
    tbl[11] = mk(0, 0, 0, 3, 0, 0, 0);
    tbl[12] = mk(255, 255, 255, 255, 255, 2, 0);
    tbl[13] = mk(50, 60, 58, 60, 57, 1, 0);
    tbl[14] = mk(56, 56, 57, 55, 56, 1, 0);
    tbl[15] = mk(55, 56, 55, 57, 55, 0, 0);

    repeat (3) @(negedge clk);
    chk_out("reset", 8'd0, 2'd0, 1'b0);
    chk("reset.hart_rate", 32'(hart_rate), 32'd0);
    reset = 1'b0;

    // Window table; state carries from one row to the next.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) send(tbl[i].s[j]);
      after_eval();
      chk_out($sformatf("vec%0d", i), tbl[i].vol, tbl[i].lvl, tbl[i].cont);
    end

    // Ready held high captures once only.
    do_reset();
    @(negedge clk);
    dsp.dsp_data  = 8'd200;
    dsp.dsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    dsp.dsp_ready = 1'b0;
    chk("held.vol", 32'(huil_vol), 32'd0);
    send(8'd0);
    send(8'd0);
    after_eval();
    chk("held.partial", 32'(huil_vol), 32'd0);
    send(8'd0);
    after_eval();
    chk_out("held.done", 8'd50, 2'd0, 1'b0);

    // Next window's first sample arrives right behind the evaluation.
    send4(8'd64);
    send(8'd200);
    chk_out("b2b.first", 8'd64, 2'd1, 1'b0);
    send(8'd0);
    send(8'd0);
    send(8'd0);
    after_eval();
    chk_out("b2b.second", 8'd50, 2'd0, 1'b0);

    // Asynchronous reset mid-window discards the partial sum.
    send4(8'd200);
    after_eval();
    chk_out("pre_rst", 8'd200, 2'd2, 1'b0);
    send(8'd255);
    send(8'd255);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 8'd0, 2'd0, 1'b0);
    chk("async_rst.hart_rate", 32'(hart_rate), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'd40);
    send(8'd40);
    send(8'd40);
    after_eval();
    chk("post_rst.partial", 32'(huil_vol), 32'd0);
    send(8'd40);
    after_eval();
    chk_out("post_rst.done", 8'd40, 2'd0, 1'b0);

    // Heart-rate measurement and level boost.
    do_reset();
    repeat (5) pulse_hart();
    repeat (4) strobe(1'b0);
    chk("heart.rate", 32'(hart_rate), HEART ? 32'd5 : 32'd0);
    send4(8'd70);
    after_eval();
    chk("heart.vol", 32'(huil_vol), 32'd70);
    chk("heart.level", 32'(stress_level), HEART ? 32'd2 : 32'd1);
    chk("heart.laag", 32'(stress_laag), 32'd0);
    repeat (3) strobe(1'b0);
    strobe(1'b1);
    chk("heart.boundary_old", 32'(hart_rate), 32'd0);
    repeat (4) strobe(1'b0);
    chk("heart.boundary_new", 32'(hart_rate), HEART ? 32'd1 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
